// File: rtl/parity_chk_ctrl_pkg.sv
// Shared types and helpers for the parity checker sequencing controller.
package parity_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Value the XOR of all five bits takes for a correctly formed word.
    localparam logic PARITY_EVEN = 1'b0;

    function automatic logic parity_err(input logic [3:0] data, input logic par);
        return (^{data, par}) != PARITY_EVEN;
    endfunction

endpackage

// File: rtl/parity_chk_ctrl_if.sv
// Word-in / result-out handshake bundle plus status outputs of the controller.
interface parity_chk_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             in_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       word_idx;
    logic             frame_done;
    logic [4:0]       err_word;

    modport master (
        output in_valid, in_data, in_par, out_ready,
        input  in_ready, out_valid, out_err, err_cnt, word_idx, frame_done, err_word
    );

    modport slave (
        input  in_valid, in_data, in_par, out_ready,
        output in_ready, out_valid, out_err, err_cnt, word_idx, frame_done, err_word
    );
endinterface

// File: rtl/parity_chk_ctrl_core.sv
// Combinational even-parity checker: 4 data bits + 1 parity bit.
module parity_chk_core
    import parity_ctrl_pkg::*;
(
    input  logic [3:0] i_data,
    input  logic       i_par,
    output logic       o_err
);
    assign o_err = (^{i_data, i_par}) != PARITY_EVEN;
endmodule

// File: rtl/parity_chk_ctrl.sv
// Sequencing controller for the parity checker datapath.
// Optional build macro: ERR_CAPTURE_EN (captures the most recent errored word).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a word; accepted word is latched into drive regs
// ST_SETTLE | checker inputs settling, counter runs down to zero
// ST_REPORT | result presented on out_valid/out_err until out_ready
module parity_chk_ctrl
    import parity_ctrl_pkg::*;
#(
    parameter int SETTLE    = 1,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    parity_chk_ctrl_if.slave   bus
);
    localparam bit         SETTLE_ZERO = (SETTLE == 0);
    localparam int         SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_M1);
    localparam logic [7:0] LAST_IDX    = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;
    localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [3:0]       r_drv_data;
    logic             r_drv_par;
    logic             r_out_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [7:0]       r_word_idx;
    logic             r_frame_done;
    logic             w_core_err;
    logic             w_load_err;
    logic             w_accept;
    logic             w_hs;
    logic             w_enter_report;

    parity_chk_core u_core (
        .i_data (r_drv_data),
        .i_par  (r_drv_par),
        .o_err  (w_core_err)
    );

    assign w_accept       = (r_state == ST_IDLE) && bus.in_valid && !clr;
    assign w_hs           = (r_state == ST_REPORT) && bus.out_ready && !clr;
    assign w_enter_report = (w_state_nxt == ST_REPORT) && (r_state != ST_REPORT);
    // With no settle time the drive regs load on the same edge REPORT is entered,
    // so the result has to come straight from the incoming word.
    assign w_load_err     = SETTLE_ZERO ? parity_err(bus.in_data, bus.in_par) : w_core_err;

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = (r_state == ST_REPORT);
    assign bus.out_err    = r_out_err;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.word_idx   = r_word_idx;
    assign bus.frame_done = r_frame_done;

    // State and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and settle counter decode; clr overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (clr) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (SETTLE_ZERO) begin
                            w_state_nxt = ST_REPORT;
                        end else begin
                            w_state_nxt = ST_SETTLE;
                            w_cnt_nxt   = SETTLE_LOAD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = ST_REPORT;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_REPORT: begin
                    if (bus.out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Checker drive registers, loaded only when a word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drv_data <= 4'd0;
            r_drv_par  <= 1'b0;
        end else if (w_accept) begin
            r_drv_data <= bus.in_data;
            r_drv_par  <= bus.in_par;
        end
    end

    // Result register: sampled once on entry to REPORT, then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_err <= 1'b0;
        end else if (clr) begin
            r_out_err <= 1'b0;
        end else if (w_enter_report) begin
            r_out_err <= w_load_err;
        end
    end

    // Frame position, saturating error count and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_word_idx   <= 8'd0;
            r_frame_done <= 1'b0;
        end else if (clr) begin
            r_err_cnt    <= '0;
            r_word_idx   <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_hs) begin
                if (r_out_err && (r_err_cnt != ERR_MAX)) begin
                    r_err_cnt <= r_err_cnt + ERR_ONE;
                end
                if (r_word_idx == LAST_IDX) begin
                    r_word_idx   <= 8'd0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_word_idx <= r_word_idx + 8'd1;
                end
            end
        end
    end

`ifdef ERR_CAPTURE_EN
    logic [4:0] r_err_word;

    // Most recent errored word, taken at its result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_word <= 5'd0;
        end else if (clr) begin
            r_err_word <= 5'd0;
        end else if (w_hs && r_out_err) begin
            r_err_word <= {r_drv_data, r_drv_par};
        end
    end

    assign bus.err_word = r_err_word;
`else
    assign bus.err_word = 5'd0;
`endif

endmodule

// File: tb/tb_parity_chk_ctrl.sv
// Self-checking bench for parity_chk_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_parity_chk_ctrl;
    localparam int P_SETTLE = 1;
    localparam int P_FRAME  = 16;
    localparam int P_CNTW   = 8;
    localparam int P_MAX    = (1 << P_CNTW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    parity_chk_ctrl_if #(.CNT_W(P_CNTW)) bus ();

    parity_chk_ctrl #(
        .SETTLE    (P_SETTLE),
        .FRAME_LEN (P_FRAME),
        .CNT_W     (P_CNTW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one word in flight, result due SETTLE+1 cycles after accept.
    int       m_cyc      = 0;
    bit       m_busy     = 0;
    int       m_ready_at = 0;
    bit [4:0] m_pend     = 0;
    int       m_err      = 0;
    int       m_idx      = 0;
    bit       m_fd       = 0;
    bit [4:0] m_ew       = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_err = 0; m_idx = 0; m_fd = 0; m_ew = 0; m_pend = 0; m_ready_at = 0;
        end else begin
            if (clr) begin
                m_busy = 0; m_err = 0; m_idx = 0; m_fd = 0; m_ew = 0;
            end else begin
                m_fd = 0;
                if (!m_busy) begin
                    if (bus.in_valid) begin
                        m_busy     = 1;
                        m_pend     = {bus.in_data, bus.in_par};
                        m_ready_at = m_cyc + 1 + P_SETTLE;
                    end
                end else if (m_cyc >= m_ready_at && bus.out_ready) begin
                    m_busy = 0;
                    if (^m_pend) begin
                        if (m_err < P_MAX) m_err++;
`ifdef ERR_CAPTURE_EN
                        m_ew = m_pend;
`endif
                    end
                    m_idx++;
                    if (m_idx == P_FRAME) begin
                        m_idx = 0;
                        m_fd  = 1;
                    end
                end
            end
            m_cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_valid;
        exp_valid = m_busy && (m_cyc >= m_ready_at);
        check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) check("out_err", 32'(bus.out_err), 32'(^m_pend));
        check("err_cnt", 32'(bus.err_cnt), 32'(m_err));
        check("word_idx", 32'(bus.word_idx), 32'(m_idx));
        check("frame_done", 32'(bus.frame_done), 32'(m_fd));
        check("err_word", 32'(bus.err_word), 32'(m_ew));
        if (bus.frame_done) fd_seen++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic p);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("send_timeout", 32'(guard), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_par   = p;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_word();
        int guard = 0;
        while (!bus.out_valid && guard < 100) begin
            tick();
            guard++;
        end
        while (bus.out_valid && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("finish_timeout", 32'(guard), 32'd0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int fd_base;
        logic [3:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_par    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_word_idx", 32'(bus.word_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean word: result two cycles after accept.
        send(4'b1010, 1'b0);
        check("t1_valid_T1", 32'(bus.out_valid), 32'd0);
        tick();
        check("t1_valid_T2", 32'(bus.out_valid), 32'd1);
        check("t1_out_err", 32'(bus.out_err), 32'd0);
        tick();
        check("t1_word_idx", 32'(bus.word_idx), 32'd1);
        check("t1_err_cnt", 32'(bus.err_cnt), 32'd0);

        // Errored word.
        send(4'b1011, 1'b0);
        tick();
        check("t2_out_err", 32'(bus.out_err), 32'd1);
        tick();
        check("t2_err_cnt", 32'(bus.err_cnt), 32'd1);
`ifdef ERR_CAPTURE_EN
        check("t2_err_word", 32'(bus.err_word), 32'b10110);
`endif

        // Backpressure for 5 cycles.
        bus.out_ready = 1'b0;
        send(4'b0001, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_err", 32'(bus.out_err), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_err_cnt", 32'(bus.err_cnt), 32'd1);
            check("bp_word_idx", 32'(bus.word_idx), 32'd2);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_rel_err_cnt", 32'(bus.err_cnt), 32'd2);
        check("bp_rel_word_idx", 32'(bus.word_idx), 32'd3);

        // Full frame from a cleared position.
        pulse_clr();
        check("clr_idle_word_idx", 32'(bus.word_idx), 32'd0);
        fd_base = fd_seen;
        for (int i = 0; i < P_FRAME; i++) begin
            send(4'($urandom), 1'($urandom));
            finish_word();
        end
        check("frame_done_now", 32'(bus.frame_done), 32'd1);
        tick();
        check("frame_pulses", 32'(fd_seen - fd_base), 32'd1);
        check("frame_wrap_idx", 32'(bus.word_idx), 32'd0);

        // Error counter saturation.
        pulse_clr();
        for (int i = 0; i < P_MAX + 5; i++) begin
            d = 4'($urandom);
            send(d, ~(^d));
            finish_word();
        end
        check("sat_err_cnt", 32'(bus.err_cnt), 32'(P_MAX));
        check("sat_word_idx", 32'(bus.word_idx), 32'((P_MAX + 5) % P_FRAME));

        // clr during SETTLE discards the word.
        send(4'b1111, 1'b0);
        pulse_clr();
        check("clr_in_ready", 32'(bus.in_ready), 32'd1);
        check("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("clr_word_idx", 32'(bus.word_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("clr_no_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Reset during REPORT.
        send(4'b0111, 1'b0);
        finish_word();
        bus.out_ready = 1'b0;
        send(4'b0011, 1'b1);
        tick();
        check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_mid_word_idx", 32'(bus.word_idx), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 4'($urandom);
            bus.in_par    = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 63) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr           = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
